// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-side bus: instruction-memory request/response, execute resolution
// inputs and the registered instruction handed to decode.
interface fetch_pc_sequencer_if;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic        ex_valid;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_valid;

    // Sequencer side.
    modport master (
        input  pc_sel, branch_target, jalr_target, ex_valid, stall,
        input  imem_ready, imem_rdata,
        output imem_req, imem_addr,
        output inst_out, inst_pc, inst_valid
    );

    // Memory / execute side.
    modport slave (
        output pc_sel, branch_target, jalr_target, ex_valid, stall,
        output imem_ready, imem_rdata,
        input  imem_req, imem_addr,
        input  inst_out, inst_pc, inst_valid
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Multicycle femtoRV32 fetch sequencer: owns the PC, fetches one word,
// holds it for execute, then registers the next PC chosen by pc_sel.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fetch_pc_sequencer_if.master          bus,
    output logic [31:0]                   epc,
    output logic                          misalign_err,
    output logic [1:0]                    state_o
);

    // Handshakes: imem_req is held with a stable imem_addr until the cycle
    // imem_ready is high, and that edge completes the read. In S_ISSUE a
    // resolution completes on an edge with ex_valid=1 and stall=0; stall
    // simply blocks it, and the same resolution is re-sampled later.
    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] epc_q, epc_d;
    logic        misalign_q, misalign_d;

    logic        resolve;
    logic [31:0] seq_pc;
    logic [31:0] jalr_aligned;
    logic [31:0] next_pc;
    logic        take_trap;
    logic        target_misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RST;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            epc_q        <= 32'h0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            epc_q        <= epc_d;
            misalign_q   <= misalign_d;
        end
    end

    assign resolve      = (state_q == S_ISSUE) && bus.ex_valid && !bus.stall;
    assign seq_pc       = pc_q + 32'd4;
    assign jalr_aligned = {bus.jalr_target[31:1], 1'b0};

    always_comb begin
        next_pc           = seq_pc;
        take_trap         = 1'b0;
        target_misaligned = 1'b0;
        case (bus.pc_sel)
            2'b00: next_pc = seq_pc;
            2'b01: begin
                next_pc           = bus.branch_target;
                target_misaligned = (bus.branch_target[1:0] != 2'b00);
            end
            2'b10: begin
                next_pc           = jalr_aligned;
                target_misaligned = (jalr_aligned[1:0] != 2'b00);
            end
            default: take_trap = 1'b1;
        endcase
        // A misaligned jump behaves like a trap but also raises the sticky flag.
        if (target_misaligned) begin
            take_trap = 1'b1;
        end
        if (take_trap) begin
            next_pc = TRAP_VEC;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        epc_d        = epc_q;
        misalign_d   = misalign_q;
        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ready) begin
                    inst_d       = bus.imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (resolve) begin
                    pc_d         = next_pc;
                    inst_valid_d = 1'b0;
                    state_d      = S_FETCH;
                    if (take_trap) begin
                        epc_d = inst_pc_q;
                    end
                    if (target_misaligned) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    assign bus.imem_req   = (state_q == S_FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign epc            = epc_q;
    assign misalign_err   = misalign_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: reset, fetch/wait states, every
// pc_sel path, traps, misalignment, PC wrap, stall and reset mid-fetch.
module tb_fetch_pc_sequencer;

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [31:0] TVEC    = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic [31:0] epc;
    logic        misalign_err;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    fetch_pc_sequencer_if bus ();

    fetch_pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (TVEC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .epc          (epc),
        .misalign_err (misalign_err),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One zero-wait fetch from the current address.
    task automatic fetch(input logic [31:0] word, input logic [31:0] exp_pc);
        chk("fetch_req", {31'h0, bus.imem_req}, 32'd1);
        chk("fetch_addr", bus.imem_addr, exp_pc);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        step();
        bus.imem_ready = 1'b0;
        chk("fetch_valid", {31'h0, bus.inst_valid}, 32'd1);
        chk("fetch_inst", bus.inst_out, word);
        chk("fetch_inst_pc", bus.inst_pc, exp_pc);
    endtask

    // Resolve the issued instruction and check the redirected fetch address.
    task automatic resolve(input logic [1:0] sel, input logic [31:0] bt,
                           input logic [31:0] jt, input logic [31:0] exp_addr);
        bus.pc_sel        = sel;
        bus.branch_target = bt;
        bus.jalr_target   = jt;
        bus.ex_valid      = 1'b1;
        step();
        bus.ex_valid = 1'b0;
        chk("resolve_valid_clr", {31'h0, bus.inst_valid}, 32'd0);
        chk("resolve_req", {31'h0, bus.imem_req}, 32'd1);
        chk("resolve_addr", bus.imem_addr, exp_addr);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.pc_sel        = 2'b00;
        bus.branch_target = 32'h0;
        bus.jalr_target   = 32'h0;
        bus.ex_valid      = 1'b0;
        bus.stall         = 1'b0;
        bus.imem_ready    = 1'b0;
        bus.imem_rdata    = 32'h0;
        step();
        step();

        chk("rst_state", {30'h0, state_o}, {30'h0, ST_RST});
        chk("rst_req", {31'h0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_inst", bus.inst_out, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_valid", {31'h0, bus.inst_valid}, 32'd0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'd0);

        rst_n = 1'b1;
        step();
        chk("first_req_state", {30'h0, state_o}, {30'h0, ST_FETCH});
        fetch(32'h0000_0013, 32'h0);
        chk("issue_req_low", {31'h0, bus.imem_req}, 32'd0);
        resolve(2'b00, 32'h0, 32'h0, 32'h4);

        // Three wait cycles at 0x4.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req", {31'h0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, 32'h4);
            chk("wait_valid", {31'h0, bus.inst_valid}, 32'd0);
        end
        fetch(32'h0000_0013, 32'h4);
        resolve(2'b00, 32'h0, 32'h0, 32'h8);

        fetch(32'h0000_0063, 32'h8);
        resolve(2'b01, 32'h40, 32'h0, 32'h40);
        fetch(32'h0000_0067, 32'h40);
        resolve(2'b10, 32'h0, 32'h81, 32'h80);
        fetch(32'h0000_006f, 32'h80);
        resolve(2'b01, 32'h20, 32'h0, 32'h20);

        fetch(32'h0000_0073, 32'h20);
        resolve(2'b11, 32'h0, 32'h0, TVEC);
        chk("sys_epc", epc, 32'h20);
        chk("sys_misalign", {31'h0, misalign_err}, 32'd0);

        fetch(32'h0000_006f, TVEC);
        resolve(2'b01, 32'h10, 32'h0, 32'h10);
        fetch(32'h0000_0063, 32'h10);
        resolve(2'b01, 32'h42, 32'h0, TVEC);
        chk("mis_epc", epc, 32'h10);
        chk("mis_flag", {31'h0, misalign_err}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            fetch(32'h0000_0013, TVEC + 32'(i * 4));
            resolve(2'b00, 32'h0, 32'h0, TVEC + 32'((i + 1) * 4));
        end
        chk("mis_sticky", {31'h0, misalign_err}, 32'd1);

        // JALR to 0x83 clears bit 0 to 0x82, still misaligned.
        fetch(32'h0000_0067, 32'h128);
        resolve(2'b10, 32'h0, 32'h83, TVEC);
        chk("jalr_mis_epc", epc, 32'h128);

        // Trap taken from the trap vector itself.
        fetch(32'h0000_0073, TVEC);
        resolve(2'b11, 32'h0, 32'h0, TVEC);
        chk("trap_at_vec_epc", epc, TVEC);

        fetch(32'h0000_006f, TVEC);
        resolve(2'b01, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 32'hFFFF_FFFC);
        resolve(2'b00, 32'h0, 32'h0, 32'h0);

        // Stall holds the resolution for two edges.
        fetch(32'h0000_0063, 32'h0);
        bus.pc_sel        = 2'b01;
        bus.branch_target = 32'h200;
        bus.ex_valid      = 1'b1;
        bus.stall         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_state", {30'h0, state_o}, {30'h0, ST_ISSUE});
            chk("stall_addr", bus.imem_addr, 32'h0);
            chk("stall_valid", {31'h0, bus.inst_valid}, 32'd1);
        end
        bus.stall = 1'b0;
        step();
        bus.ex_valid = 1'b0;
        chk("unstall_addr", bus.imem_addr, 32'h200);
        chk("unstall_req", {31'h0, bus.imem_req}, 32'd1);

        // Reset in the middle of a pending fetch.
        rst_n = 1'b0;
        step();
        chk("midrst_req", {31'h0, bus.imem_req}, 32'd0);
        chk("midrst_addr", bus.imem_addr, 32'h0);
        chk("midrst_state", {30'h0, state_o}, {30'h0, ST_RST});
        chk("midrst_epc", epc, 32'h0);
        chk("midrst_misalign", {31'h0, misalign_err}, 32'd0);

        // A late ready seen in S_RST must not capture anything.
        rst_n          = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("late_ready_state", {30'h0, state_o}, {30'h0, ST_FETCH});
        chk("late_ready_valid", {31'h0, bus.inst_valid}, 32'd0);
        chk("late_ready_inst", bus.inst_out, 32'h0);
        step();
        bus.imem_ready = 1'b0;
        chk("refetch_valid", {31'h0, bus.inst_valid}, 32'd1);
        chk("refetch_inst", bus.inst_out, 32'hDEAD_BEEF);
        chk("refetch_inst_pc", bus.inst_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
